// File: rtl/pe_row_injector.sv
// pe_row_injector
//   Upstream feeder for the first-in-row PE of the Nanci mesh. Host words
//   {addr,data} are taken over a valid/ready handshake into a small FIFO. One
//   word is presented on o_PE_l per PE phase of SORT_CYCLES+COMPUTE_CYCLES
//   cycles, and the null word (all zeros) is presented when the FIFO is empty.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   i_valid  in   host word valid
//   i_word   in   host word {addr,data}
//   o_ready  out  FIFO can accept a word this cycle (not full)
//   o_PE_l   out  registered word driving the PE's i_PE_l
//   o_slot   out  1-cycle pulse, o_PE_l was updated at this phase start
//   o_count  out  FIFO occupancy
module pe_row_injector #(
  parameter int ADDR_WIDTH     = 3,
  parameter int DATA_WIDTH     = 3,
  parameter int SORT_CYCLES    = 1,
  parameter int COMPUTE_CYCLES = 1,
  parameter int DEPTH          = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_valid,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_word,
  output logic                             o_ready,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_PE_l,
  output logic                             o_slot,
  output logic [$clog2(DEPTH):0]           o_count
);

  localparam int W         = ADDR_WIDTH + DATA_WIDTH;
  localparam int PHASE_LEN = SORT_CYCLES + COMPUTE_CYCLES;
  localparam int AW        = $clog2(DEPTH);
  localparam int PW        = AW + 1;
  localparam int CW        = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] phase_q, phase_d;
  logic [W-1:0]  pe_l_q, pe_l_d;
  logic          slot_q, slot_d;
  logic [W-1:0]  mem_q [DEPTH];

  logic empty, full, push, pop, slot_start;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign slot_start = (phase_q == '0);
  // Push depends on the pre-edge full flag only, so a same-edge pop never makes room.
  assign push       = i_valid && !full;
  assign pop        = slot_start && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    phase_d  = phase_q;
    pe_l_d   = pe_l_q;
    slot_d   = 1'b0;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (phase_q == CW'(PHASE_LEN - 1)) phase_d = '0;
    else                                phase_d = phase_q + 1'b1;
    // The head is read from registered storage, so a word written on this
    // same edge cannot depart until the next slot start.
    if (slot_start) begin
      slot_d = 1'b1;
      pe_l_d = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      phase_q  <= '0;
      pe_l_q   <= '0;
      slot_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      phase_q  <= phase_d;
      pe_l_q   <= pe_l_d;
      slot_q   <= slot_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= i_word;
  end

  assign o_ready = !full;
  assign o_PE_l  = pe_l_q;
  assign o_slot  = slot_q;
  assign o_count = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_pe_row_injector.sv
// Testbench for pe_row_injector: two instances (PHASE_LEN=2 and PHASE_LEN=1)
// share the same stimulus; each is compared every cycle against its own
// scoreboard queue, filled on accepted pushes and drained at slot starts.
module tb_pe_row_injector;

  localparam int DEPTH = 4;
  localparam int W     = 6;
  localparam int PL0   = 2;
  localparam int PL1   = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic [W-1:0] i_word = '0;

  logic         ready0, slot0, ready1, slot1;
  logic [W-1:0] pe0, pe1;
  logic [2:0]   cnt0, cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard / reference state per instance.
  logic [W-1:0] q0[$], q1[$];
  int           ph0, ph1;
  logic [W-1:0] eout0, eout1;
  logic         eslot0, eslot1;

  always #5 clk = ~clk;

  pe_row_injector #(
    .ADDR_WIDTH(3), .DATA_WIDTH(3), .SORT_CYCLES(1), .COMPUTE_CYCLES(1), .DEPTH(DEPTH)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_word(i_word),
    .o_ready(ready0), .o_PE_l(pe0), .o_slot(slot0), .o_count(cnt0)
  );

  pe_row_injector #(
    .ADDR_WIDTH(3), .DATA_WIDTH(3), .SORT_CYCLES(0), .COMPUTE_CYCLES(1), .DEPTH(DEPTH)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_word(i_word),
    .o_ready(ready1), .o_PE_l(pe1), .o_slot(slot1), .o_count(cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete();
    ph0 = 0; ph1 = 0;
    eout0 = '0; eout1 = '0;
    eslot0 = 1'b0; eslot1 = 1'b0;
  endtask

  // Reference behaviour at one rising edge, using pre-edge inputs.
  task automatic model_edge();
    bit full0, full1;
    if (!rst_n) begin
      model_reset();
      return;
    end
    full0 = (q0.size() == DEPTH);
    full1 = (q1.size() == DEPTH);
    eslot0 = (ph0 == 0);
    if (eslot0) eout0 = (q0.size() != 0) ? q0.pop_front() : '0;
    eslot1 = (ph1 == 0);
    if (eslot1) eout1 = (q1.size() != 0) ? q1.pop_front() : '0;
    if (i_valid && !full0) q0.push_back(i_word);
    if (i_valid && !full1) q1.push_back(i_word);
    ph0 = (ph0 + 1) % PL0;
    ph1 = (ph1 + 1) % PL1;
  endtask

  task automatic check_all();
    check("pe0",    32'(pe0),    32'(eout0));
    check("slot0",  32'(slot0),  32'(eslot0));
    check("count0", 32'(cnt0),   32'(q0.size()));
    check("ready0", 32'(ready0), 32'(q0.size() != DEPTH));
    check("pe1",    32'(pe1),    32'(eout1));
    check("slot1",  32'(slot1),  32'(eslot1));
    check("count1", 32'(cnt1),   32'(q1.size()));
    check("ready1", 32'(ready1), 32'(q1.size() != DEPTH));
  endtask

  // Drive inputs, take one edge, update the model, check 1 time unit later.
  task automatic step(input logic v, input logic [W-1:0] w);
    i_valid = v;
    i_word  = w;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  logic [W-1:0] fill_words [5];

  initial begin
    model_reset();
    fill_words[0] = 6'b001001; fill_words[1] = 6'b010010; fill_words[2] = 6'b011011;
    fill_words[3] = 6'b100100; fill_words[4] = 6'b101101;

    // Held in reset with valid asserted: nothing may be accepted or emitted.
    #1;
    check_all();
    for (int i = 0; i < 4; i++) step(1'b1, 6'(i + 7));

    rst_n = 1'b1;
    idle(3);

    // Single word, then drain to nulls.
    step(1'b1, 6'b001101);
    idle(6);

    // Five back-to-back words; the later ones hit a full FIFO.
    for (int i = 0; i < 5; i++) step(1'b1, fill_words[i]);
    idle(12);

    // Sustained valid keeps the PHASE_LEN=2 FIFO full across slot-start pops.
    for (int i = 0; i < 10; i++) step(1'b1, 6'(40 + i));
    idle(12);

    // Null words from the host are queued like any other.
    step(1'b1, 6'b000000);
    step(1'b1, 6'b111111);
    step(1'b1, 6'b000000);
    idle(8);

    // Random traffic.
    for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 1)), 6'($urandom));
    idle(12);

    // Reset mid-stream, asserted between edges.
    for (int i = 0; i < 3; i++) step(1'b1, 6'(50 + i));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pe0",   32'(pe0),  32'h0);
    check("async_pe1",   32'(pe1),  32'h0);
    check("async_cnt0",  32'(cnt0), 32'h0);
    check("async_cnt1",  32'(cnt1), 32'h0);
    check("async_slot0", 32'(slot0), 32'h0);
    model_reset();
    step(1'b1, 6'b010101);
    step(1'b0, '0);
    rst_n = 1'b1;
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
